line_buffer_3x3: RTL and testbench

// Raster-order pixel streamer feeding the single-channel 3x3 convolution engine. Buffers two image rows.

---
 rtl/line_buffer_3x3.sv | 162 ++++++++++++++++
 tb/tb_line_buffer_3x3.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_3x3.sv
// line_buffer_3x3: raster-order pixel streamer for a 3x3 convolution engine.
// Two line buffers hold the previous two image rows. Every complete
// (no-padding) 3x3 window is presented on p00..p22 and held until the
// consumer acknowledges it.
//
// Handshakes:
//   pixel side : a pixel is transferred in any cycle where pix_valid and
//                pix_ready are both 1; pix_ready never depends on pix_valid.
//   window side: win_valid stays 1 with stable taps/coordinates until a
//                cycle with win_ack=1; win_ack is ignored while win_valid=0.
module line_buffer_3x3 #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    localparam int WR_W = (IMG_H - 2 > 1) ? $clog2(IMG_H - 2) : 1,
    localparam int WC_W = (IMG_W - 2 > 1) ? $clog2(IMG_W - 2) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [7:0]      pix_in,
    input  logic            pix_valid,
    output logic            pix_ready,
    output logic [7:0]      p00,
    output logic [7:0]      p01,
    output logic [7:0]      p02,
    output logic [7:0]      p10,
    output logic [7:0]      p11,
    output logic [7:0]      p12,
    output logic [7:0]      p20,
    output logic [7:0]      p21,
    output logic [7:0]      p22,
    output logic            win_valid,
    input  logic            win_ack,
    output logic [WR_W-1:0] win_row,
    output logic [WC_W-1:0] win_col,
    output logic            frame_done
);

    localparam int ROW_W = $clog2(IMG_H);
    localparam int COL_W = $clog2(IMG_W);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [WR_W-1:0]  WR_LAST  = WR_W'(IMG_H - 3);
    localparam logic [WC_W-1:0]  WC_LAST  = WC_W'(IMG_W - 3);

    // Incoming pixel position
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;

    // lb0 = row r-1, lb1 = row r-2 (not reset: always rewritten before use)
    logic [7:0] lb0_q [IMG_W];
    logic [7:0] lb1_q [IMG_W];

    // Window taps, [row][col], [0][0] = top-left
    logic [7:0] win_q [3][3];

    logic            win_valid_q, win_valid_d;
    logic [WR_W-1:0] win_row_q, win_row_d;
    logic [WC_W-1:0] win_col_q, win_col_d;
    logic            frame_done_q, frame_done_d;

    logic accept;
    logic win_complete;

    assign pix_ready    = en & (~win_valid_q | win_ack);
    assign accept       = pix_valid & pix_ready;
    assign win_complete = accept & (row_q >= ROW_TWO) & (col_q >= COL_TWO);

    // Next-state for position counters, window status and frame-done pulse
    always_comb begin
        row_d        = row_q;
        col_d        = col_q;
        win_valid_d  = win_valid_q;
        win_row_d    = win_row_q;
        win_col_d    = win_col_q;
        frame_done_d = win_ack & win_valid_q & (win_row_q == WR_LAST) & (win_col_q == WC_LAST);

        if (accept) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_ONE;
            end else begin
                col_d = col_q + COL_ONE;
            end
        end

        // A newly completed window replaces the released one with no gap
        if (win_complete) begin
            win_valid_d = 1'b1;
            win_row_d   = WR_W'(row_q - ROW_TWO);
            win_col_d   = WC_W'(col_q - COL_TWO);
        end else if (win_ack && win_valid_q) begin
            win_valid_d = 1'b0;
        end
    end

    // Control and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            row_q        <= '0;
            col_q        <= '0;
            win_valid_q  <= 1'b0;
            win_row_q    <= '0;
            win_col_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            row_q        <= row_d;
            col_q        <= col_d;
            win_valid_q  <= win_valid_d;
            win_row_q    <= win_row_d;
            win_col_q    <= win_col_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Window shift register: shift left, new right column from line buffers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= win_q[r][2];
            end
            win_q[0][2] <= lb1_q[col_q];
            win_q[1][2] <= lb0_q[col_q];
            win_q[2][2] <= pix_in;
        end
    end

    // Line buffer storage: push the column down one row on every accept
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_q[col_q] <= lb0_q[col_q];
            lb0_q[col_q] <= pix_in;
        end
    end

    assign p00        = win_q[0][0];
    assign p01        = win_q[0][1];
    assign p02        = win_q[0][2];
    assign p10        = win_q[1][0];
    assign p11        = win_q[1][1];
    assign p12        = win_q[1][2];
    assign p20        = win_q[2][0];
    assign p21        = win_q[2][1];
    assign p22        = win_q[2][2];
    assign win_valid  = win_valid_q;
    assign win_row    = win_row_q;
    assign win_col    = win_col_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_line_buffer_3x3.sv
// tb_line_buffer_3x3: directed bench for line_buffer_3x3 on a 4x4 image.
module tb_line_buffer_3x3;

  localparam int W = 4;
  localparam int H = 4;
  localparam int NPIX = W * H;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       en;
  logic [7:0] pix_in;
  logic       pix_valid;
  logic       pix_ready;
  logic [7:0] p00, p01, p02, p10, p11, p12, p20, p21, p22;
  logic       win_valid;
  logic       win_ack;
  logic [0:0] win_row;
  logic [0:0] win_col;
  logic       frame_done;

  line_buffer_3x3 #(.IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .p00        (p00),
    .p01        (p01),
    .p02        (p02),
    .p10        (p10),
    .p11        (p11),
    .p12        (p12),
    .p20        (p20),
    .p21        (p21),
    .p22        (p22),
    .win_valid  (win_valid),
    .win_ack    (win_ack),
    .win_row    (win_row),
    .win_col    (win_col),
    .frame_done (frame_done)
  );

  logic [71:0] taps;
  assign taps = {p00, p01, p02, p10, p11, p12, p20, p21, p22};

  // ---------------- counters and reference model state ----------------
  int n_checks = 0;
  int n_errs   = 0;

  int  base;        // pixel value offset of the frame being sent
  int  idx;         // next pixel index within the frame
  int  left;        // pixels still to send in the current stream
  bit  m_valid;     // model: window held
  int  m_r, m_c;    // model: held window coordinates
  int  m_base;      // model: frame base of held window
  int  m_seen;      // model: cycles the window has been visible

  int          dut_wins;
  int          dut_fd;
  logic [71:0] first_win;
  logic [71:0] last_win;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] exp_taps(input int b, input int r, input int c);
    logic [71:0] res;
    res = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        res = {res[63:0], 8'(b + (r + i) * W + (c + j) + 1)};
      end
    end
    return res;
  endfunction

  task automatic begin_frame();
    dut_wins  = 0;
    dut_fd    = 0;
    first_win = 'x;
    last_win  = 'x;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int n);
    rst       = 1'b1;
    en        = 1'b0;
    pix_valid = 1'b0;
    win_ack   = 1'b0;
    pix_in    = '0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    rst     = 1'b0;
    idx     = 0;
    m_valid = 1'b0;
    m_seen  = 0;
    chk("rst_win_valid", 72'(win_valid), 72'(0));
    chk("rst_frame_done", 72'(frame_done), 72'(0));
    chk("rst_taps", taps, 72'(0));
    chk("rst_win_row", 72'(win_row), 72'(0));
    chk("rst_win_col", 72'(win_col), 72'(0));
  endtask

  // One clock cycle: drive inputs, check ready, advance model, check outputs.
  task automatic step(input bit en_v, input bit pv_v, input bit ack_v);
    bit exp_ready;
    bit acc;
    bit fd_exp;
    bit was_valid;
    int r;
    int c;
    en        = en_v;
    pix_valid = pv_v;
    win_ack   = ack_v;
    pix_in    = 8'(base + idx + 1);
    #1;
    exp_ready = en_v && (!m_valid || ack_v);
    chk("pix_ready", 72'(pix_ready), 72'(exp_ready));
    acc       = pv_v && exp_ready;
    fd_exp    = ack_v && m_valid && (m_r == H - 3) && (m_c == W - 3);
    was_valid = win_valid;
    if (ack_v && m_valid) m_valid = 1'b0;
    if (acc) begin
      r = idx / W;
      c = idx % W;
      if (r >= 2 && c >= 2) begin
        m_valid = 1'b1;
        m_r     = r - 2;
        m_c     = c - 2;
        m_base  = base;
        m_seen  = -1;
      end
      idx++;
      left--;
      if (idx == NPIX) idx = 0;
    end
    if (m_valid) m_seen++;
    @(posedge clk);
    #1;
    chk("win_valid", 72'(win_valid), 72'(m_valid));
    chk("frame_done", 72'(frame_done), 72'(fd_exp));
    if (m_valid) begin
      chk("taps", taps, exp_taps(m_base, m_r, m_c));
      chk("win_row", 72'(win_row), 72'(m_r));
      chk("win_col", 72'(win_col), 72'(m_c));
    end
    if (win_valid && (!was_valid || ack_v)) dut_wins++;
    if (frame_done) dut_fd++;
    if (win_valid && win_row == 1'b0 && win_col == 1'b0) first_win = taps;
    if (win_valid && win_row == 1'b1 && win_col == 1'b1) last_win = taps;
  endtask

  // Send the rest of the frame, acking each window one cycle after it shows.
  task automatic stream_frame();
    int budget;
    budget = 0;
    left   = NPIX - idx;
    while ((left > 0 || m_valid) && budget < 200) begin
      step(1'b1, left > 0, m_valid && m_seen >= 1);
      budget++;
    end
    chk("stream_in_budget", 72'(budget < 200), 72'(1));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    base = 0;
    left = 0;
    begin_frame();
    do_reset(2);

    // Frame A: fill to the first window
    repeat (11) step(1'b1, 1'b1, 1'b0);
    chk("first_win_taps", taps, 72'h01_02_03_05_06_07_09_0a_0b);
    chk("first_win_row", 72'(win_row), 72'(0));
    chk("first_win_col", 72'(win_col), 72'(0));

    // Backpressure: window held 9 cycles while a pixel waits
    repeat (9) begin
      step(1'b1, 1'b1, 1'b0);
      chk("hold_taps", taps, 72'h01_02_03_05_06_07_09_0a_0b);
    end

    // Ack together with accept of pixel 12: next window with no gap
    step(1'b1, 1'b1, 1'b1);
    chk("gapless_valid", 72'(win_valid), 72'(1));
    chk("win01_taps", taps, 72'h02_03_04_06_07_08_0a_0b_0c);
    chk("win01_col", 72'(win_col), 72'(1));

    stream_frame();
    chk("a_windows", 72'(dut_wins), 72'(4));
    chk("a_frame_done", 72'(dut_fd), 72'(1));
    chk("a_last_win", last_win, 72'h06_07_08_0a_0b_0c_0e_0f_10);

    // Frame B back to back, pixels 101..116
    begin_frame();
    base = 100;
    stream_frame();
    chk("b_windows", 72'(dut_wins), 72'(4));
    chk("b_frame_done", 72'(dut_fd), 72'(1));
    chk("b_first_win", first_win, 72'h65_66_67_69_6a_6b_6d_6e_6f);
    chk("b_last_win", last_win, 72'h6a_6b_6c_6e_6f_70_72_73_74);

    // Reset after pixel 10, then a fresh frame
    begin_frame();
    base = 0;
    repeat (10) step(1'b1, 1'b1, 1'b0);
    do_reset(1);
    begin_frame();
    stream_frame();
    chk("r_windows", 72'(dut_wins), 72'(4));
    chk("r_frame_done", 72'(dut_fd), 72'(1));
    chk("r_first_win", first_win, 72'h01_02_03_05_06_07_09_0a_0b);
    chk("r_last_win", last_win, 72'h06_07_08_0a_0b_0c_0e_0f_10);

    // en low for 5 cycles mid-row (one with a stray ack), then resume
    begin_frame();
    repeat (5) step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    repeat (4) step(1'b0, 1'b1, 1'b0);
    stream_frame();
    chk("e_windows", 72'(dut_wins), 72'(4));
    chk("e_frame_done", 72'(dut_fd), 72'(1));
    chk("e_first_win", first_win, 72'h01_02_03_05_06_07_09_0a_0b);
    chk("e_last_win", last_win, 72'h06_07_08_0a_0b_0c_0e_0f_10);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errs);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
